divider64x32: RTL and testbench

Sequential unsigned divider: 64-bit dividend by 32-bit divisor, producing a 32-bit quotient and a 32-bit remainder. It uses radix-2 restoring division, one quotient bit per clock. It is the inverse companion of the 32x32 Vedic multiplier in the matrix datapath: it shares the same single-cycle `start` / `valid_out` handshake, so a multiplier product can be fed straight back for normalisation and checking.

---
 rtl/divider_pkg.sv | 21 ++
 rtl/div_step.sv | 27 ++
 rtl/divider64x32.sv | 129 ++++++++++++
 tb/tb_divider64x32.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential 2*DW / DW restoring divider.
package divider_pkg;

  // Default divisor / quotient / remainder width; the dividend is twice this.
  localparam int DIV_DW = 32;

  // Widest DW the error-path constant below can serve.
  localparam int MAX_DW = 64;

  // Quotient reported on both error paths (divide-by-zero and overflow),
  // sliced down to DW bits by the user.
  localparam logic [MAX_DW-1:0] QUO_ALL_ONES = '1;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step, purely combinational.
// Shifts the partial remainder left by one (pulling in the next dividend
// bit), subtracts the divisor when it fits and reports the quotient bit.
module div_step
  import divider_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic [DW-1:0] i_r,
  input  logic          i_q_msb,
  input  logic [DW-1:0] i_divisor,
  output logic [DW-1:0] o_r,
  output logic          o_q_bit
);

  logic [DW-1:0] w_shifted;
  logic [DW-1:0] w_diff;

  // The shifted remainder is DW+1 bits wide. Its top bit is i_r[DW-1]; when
  // that bit is set the value already exceeds any DW-bit divisor, so the
  // subtraction always succeeds and the result fits back into DW bits.
  assign w_shifted = {i_r[DW-2:0], i_q_msb};
  assign o_q_bit   = i_r[DW-1] | (w_shifted >= i_divisor);
  assign w_diff    = w_shifted - i_divisor;
  assign o_r       = o_q_bit ? w_diff : w_shifted;

endmodule

// File: rtl/divider64x32.sv
// Sequential unsigned divider: 2*DW-bit dividend / DW-bit divisor, one
// quotient bit per clock. Single-cycle start / valid_out handshake shared
// with the Vedic multiplier so products can be fed straight back.
module divider64x32
  import divider_pkg::*;
#(
  parameter int DW = DIV_DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  input  logic            start,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            valid_out,
  output logic            busy,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int              CW        = $clog2(DW);
  localparam logic [CW-1:0]   LAST_STEP = CW'(DW - 1);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_rem;       // partial remainder R
  logic [DW-1:0] r_quo;       // dividend low half shifting out, quotient shifting in
  logic [DW-1:0] r_divisor;
  logic          r_dbz_pend;  // DONE reports divide-by-zero (else overflow)

  logic [DW-1:0] w_div_hi;
  logic [DW-1:0] w_div_lo;
  logic [DW-1:0] w_rem_next;
  logic          w_q_bit;
  logic [DW-1:0] w_quo_next;

  assign w_div_hi   = dividend[2*DW-1:DW];
  assign w_div_lo   = dividend[DW-1:0];
  assign w_quo_next = {r_quo[DW-2:0], w_q_bit};

  div_step #(.DW(DW)) u_step (
    .i_r      (r_rem),
    .i_q_msb  (r_quo[DW-1]),
    .i_divisor(r_divisor),
    .o_r      (w_rem_next),
    .o_q_bit  (w_q_bit)
  );

  // Controller, iteration datapath and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the small operand/work registers are reset as well, so an
      // aborted operation leaves no stale state behind and no X reaches sim.
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_dbz_pend  <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      valid_out   <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge register values regardless of statement order.
      valid_out <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rem     <= w_div_hi;
            r_quo     <= w_div_lo;
            r_divisor <= divisor;
            r_count   <= '0;
            busy      <= 1'b1;
            if (divisor == '0) begin
              r_dbz_pend <= 1'b1;
              r_state    <= ST_DONE;
            end else if (w_div_hi >= divisor) begin
              r_dbz_pend <= 1'b0;
              r_state    <= ST_DONE;
            end else begin
              r_dbz_pend <= 1'b0;
              r_state    <= ST_CALC;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        ST_CALC: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST_STEP) begin
            quotient    <= w_quo_next;
            remainder   <= w_rem_next;
            valid_out   <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        ST_DONE: begin
          // r_quo still holds the dividend's low half on this path.
          quotient    <= QUO_ALL_ONES[DW-1:0];
          remainder   <= r_dbz_pend ? r_quo : '0;
          div_by_zero <= r_dbz_pend;
          overflow    <= ~r_dbz_pend;
          valid_out   <= 1'b1;
          // busy stays up through the error-path valid_out cycle.
          busy        <= 1'b1;
          r_state     <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider64x32.sv
// Self-checking bench for divider64x32: directed vector table, start/reset
// corner sequences and back-to-back divides of random products.
module tb_divider64x32;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        start;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        valid_out;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  divider64x32 dut (
    .clk        (clk),
    .reset      (reset),
    .dividend   (dividend),
    .divisor    (divisor),
    .start      (start),
    .quotient   (quotient),
    .remainder  (remainder),
    .valid_out  (valid_out),
    .busy       (busy),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at a negedge; leaves start low at the negedge after the accept edge.
  task automatic start_op(input logic [63:0] dd, input logic [31:0] dv);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts negedges after the accept edge until valid_out; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] q, input logic [31:0] r,
                          input logic dbz, input logic ovf, input int lat_exp);
    int lat;
    wait_valid(lat);
    check({tag, " latency"}, 64'(lat), 64'(lat_exp));
    check({tag, " quotient"}, 64'(quotient), 64'(q));
    check({tag, " remainder"}, 64'(remainder), 64'(r));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(dbz));
    check({tag, " overflow"}, 64'(overflow), 64'(ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " quotient"}, 64'(quotient), 64'd0);
    check({tag, " remainder"}, 64'(remainder), 64'd0);
    check({tag, " valid_out"}, 64'(valid_out), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'd0);
    check({tag, " overflow"}, 64'(overflow), 64'd0);
  endtask

  initial begin
    int          valid_cnt;
    int          first_lat;
    logic [31:0] cap_q;
    logic [31:0] cap_r;
    logic [31:0] ra[10];
    logic [31:0] rb[10];

    //          dividend                 divisor        quotient       remainder   dbz   ovf  lat
    vecs[0] = '{64'd100,                 32'd7,         32'd14,        32'd2,      1'b0, 1'b0, 32};
    vecs[1] = '{64'hFFFFFFFE_00000001,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,      1'b0, 1'b0, 32};
    vecs[2] = '{64'h00000001_12345678,   32'd0,         32'hFFFFFFFF,  32'h12345678, 1'b1, 1'b0, 1};
    vecs[3] = '{64'h00000001_00000000,   32'd1,         32'hFFFFFFFF,  32'd0,      1'b0, 1'b1, 1};
    vecs[4] = '{64'd50,                  32'd5,         32'd10,        32'd0,      1'b0, 1'b0, 32};
    vecs[5] = '{64'd0,                   32'd3,         32'd0,         32'd0,      1'b0, 1'b0, 32};
    vecs[6] = '{64'h00000005_00000000,   32'd5,         32'hFFFFFFFF,  32'd0,      1'b0, 1'b1, 1};
    vecs[7] = '{64'h00000004_00000000,   32'd5,         32'hCCCCCCCC,  32'd4,      1'b0, 1'b0, 32};
    vecs[8] = '{64'd7,                   32'd100,       32'd0,         32'd7,      1'b0, 1'b0, 32};

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed table: result, flags, latency, busy and pulse width.
    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_op(vecs[i].dd, vecs[i].dv);
      check({tag, " busy after start"}, 64'(busy), 64'd1);
      check_op(tag, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, vecs[i].lat);
      check({tag, " busy at valid"}, 64'(busy), (vecs[i].lat == 1) ? 64'd1 : 64'd0);
      @(negedge clk);
      check({tag, " valid pulse end"}, 64'(valid_out), 64'd0);
      check({tag, " busy idle"}, 64'(busy), 64'd0);
    end

    // Extra start pulses at cycles 5 and 20 of a running divide are ignored.
    start_op(64'd1000, 32'd3);
    valid_cnt = 0;
    first_lat = -1;
    cap_q     = '0;
    cap_r     = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        valid_cnt++;
        if (first_lat < 0) begin
          first_lat = c;
          cap_q     = quotient;
          cap_r     = remainder;
        end
      end
      if (c == 5 || c == 20) begin
        start    = 1'b1;
        dividend = 64'd81;
        divisor  = (c == 5) ? 32'd9 : 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    check("ignore_start valid count", 64'(valid_cnt), 64'd1);
    check("ignore_start latency", 64'(first_lat), 64'd32);
    check("ignore_start quotient", 64'(cap_q), 64'd333);
    check("ignore_start remainder", 64'(cap_r), 64'd1);
    check("ignore_start div_by_zero", 64'(div_by_zero), 64'd0);

    // Reset at cycle 10 of an operation aborts it with no valid_out.
    start_op(64'h00000000_DEADBEEF, 32'h100);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    valid_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid_out === 1'b1) valid_cnt++;
    end
    check("abort no valid", 64'(valid_cnt), 64'd0);
    start_op(64'd50, 32'd5);
    check_op("after_abort", 32'd10, 32'd0, 1'b0, 1'b0, 32);
    @(negedge clk);

    // Random products, each new start issued in the previous valid_out cycle.
    for (int k = 0; k < 10; k++) begin
      ra[k] = $urandom;
      rb[k] = $urandom;
      if (rb[k] == 32'd0) rb[k] = 32'd1;
    end
    start_op({32'd0, ra[0]} * {32'd0, rb[0]}, rb[0]);
    for (int k = 0; k < 10; k++) begin
      check_op($sformatf("rand%0d", k), ra[k], 32'd0, 1'b0, 1'b0, 32);
      if (k < 9) start_op({32'd0, ra[k+1]} * {32'd0, rb[k+1]}, rb[k+1]);
    end
    @(negedge clk);
    check("rand final pulse end", 64'(valid_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
